// File: rtl/fnd_value_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fnd_value_ctrl : debounced run/clear/mode buttons and start/stop up-counter
// Rev 1.0 - initial release
// ---------------------------------------------------------------------------
module fnd_value_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int TICK_CYCLES     = 10_000_000
) (
  input  logic       iCLK,
  input  logic       inReset,
  input  logic       iBtnRun,
  input  logic       iBtnClr,
  input  logic       iBtnMode,
  output logic [7:0] oHex,
  output logic       oDisplayMode,
  output logic       oRunning
);

  localparam int c_DW   = $clog2(DEBOUNCE_CYCLES);
  localparam int c_TW   = $clog2(TICK_CYCLES);
  localparam int c_RUN  = 0;
  localparam int c_CLR  = 1;
  localparam int c_MODE = 2;
  localparam logic [c_DW-1:0] c_DEB_LAST  = c_DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [c_TW-1:0] c_TICK_LAST = c_TW'(TICK_CYCLES - 1);

  logic [2:0] w_btn;
  logic [2:0] w_press;

  assign w_btn = {iBtnMode, iBtnClr, iBtnRun};

  for (genvar gi = 0; gi < 3; gi++) begin : g_btn
    logic [1:0]      r_sync;
    logic            r_deb;
    logic            r_deb_d;
    logic            r_evt;
    logic [c_DW-1:0] r_cnt;

    always_ff @(posedge iCLK or negedge inReset) begin
      if (!inReset) begin
        r_sync  <= '0;
        r_deb   <= 1'b0;
        r_deb_d <= 1'b0;
        r_evt   <= 1'b0;
        r_cnt   <= '0;
      end else begin
        r_sync  <= {r_sync[0], w_btn[gi]};
        r_deb_d <= r_deb;
        r_evt   <= r_deb & ~r_deb_d;
        if (r_sync[1] == r_deb) begin
          r_cnt <= '0;
        end else if (r_cnt == c_DEB_LAST) begin
          r_deb <= r_sync[1];
          r_cnt <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end

    assign w_press[gi] = r_evt;
  end

  typedef enum logic {ST_STOP = 1'b0, ST_RUN = 1'b1} state_t;

  state_t          r_state;
  logic [c_TW-1:0] r_pre;
  logic [7:0]      r_hex;
  logic            r_mode;
  logic            r_running;
  logic            w_tick;
  logic            w_mode_next;
  logic            w_zero;
  logic [7:0]      w_inc;

  // The increment wraps against the mode that will be in force after this edge.
  always_comb begin
    w_tick      = (r_state == ST_RUN) && (r_pre == c_TICK_LAST);
    w_mode_next = r_mode ^ w_press[c_MODE];
    w_zero      = w_press[c_MODE] && !r_mode && (r_hex > 8'd99);
    if (w_mode_next && (r_hex == 8'd99)) begin
      w_inc = 8'd0;
    end else begin
      w_inc = r_hex + 8'd1;
    end
  end

  always_ff @(posedge iCLK or negedge inReset) begin
    if (!inReset) begin
      r_state   <= ST_STOP;
      r_running <= 1'b0;
      r_mode    <= 1'b0;
      r_pre     <= '0;
      r_hex     <= '0;
    end else begin
      if (w_press[c_RUN]) begin
        r_state   <= (r_state == ST_RUN) ? ST_STOP : ST_RUN;
        r_running <= (r_state != ST_RUN);
      end
      r_mode <= w_mode_next;
      if (w_press[c_CLR]) begin
        r_pre <= '0;
      end else if (r_state == ST_RUN) begin
        r_pre <= w_tick ? '0 : r_pre + 1'b1;
      end
      if (w_press[c_CLR] || w_zero) begin
        r_hex <= '0;
      end else if (w_tick) begin
        r_hex <= w_inc;
      end
    end
  end

  assign oHex         = r_hex;
  assign oDisplayMode = r_mode;
  assign oRunning     = r_running;

endmodule
`default_nettype wire

// File: tb/tb_fnd_value_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_fnd_value_ctrl : scoreboard bench, behavioural model vs fnd_value_ctrl
// Rev 1.0 - initial release
// ---------------------------------------------------------------------------
module tb_fnd_value_ctrl;

  localparam int DEB  = 4;
  localparam int TICK = 10;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] raw   = '0;
  logic [7:0] hex;
  logic       mode;
  logic       run;

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;

  typedef struct {
    int cyc;
    int hex;
    bit mode;
    bit run;
  } exp_t;

  exp_t q[$];

  int         m_hex;
  int         m_pre;
  bit         m_mode;
  bit         m_run;
  logic [7:0] hist [3];
  logic [2:0] m_deb;
  logic [2:0] rise1;
  logic [2:0] rise2;

  fnd_value_ctrl #(
    .DEBOUNCE_CYCLES(DEB),
    .TICK_CYCLES    (TICK)
  ) dut (
    .iCLK        (clk),
    .inReset     (rst_n),
    .iBtnRun     (raw[0]),
    .iBtnClr     (raw[1]),
    .iBtnMode    (raw[2]),
    .oHex        (hex),
    .oDisplayMode(mode),
    .oRunning    (run)
  );

  always #5 clk = ~clk;

  // Reference model: a level is accepted once DEB consecutive synchronised
  // samples disagree with it; presses act two edges after acceptance.
  always @(posedge clk or negedge rst_n) begin : model
    logic [2:0] rose;
    logic [2:0] apply;
    bit         all_diff;
    bit         tick;
    bit         nmode;
    bit         zero;
    int         ohex;
    bit         omode;
    bit         orun;
    exp_t       e;
    if (!rst_n) begin
      m_hex  = 0;
      m_pre  = 0;
      m_mode = 0;
      m_run  = 0;
      m_deb  = '0;
      rise1  = '0;
      rise2  = '0;
      for (int b = 0; b < 3; b++) hist[b] = '0;
    end else begin
      cyc++;
      ohex  = m_hex;
      omode = m_mode;
      orun  = m_run;
      rose  = '0;
      for (int b = 0; b < 3; b++) begin
        hist[b]  = {hist[b][6:0], raw[b]};
        all_diff = 1;
        for (int j = 0; j < DEB; j++) if (hist[b][2+j] == m_deb[b]) all_diff = 0;
        if (all_diff) begin
          m_deb[b] = ~m_deb[b];
          rose[b]  = m_deb[b];
        end
      end
      apply = rise2;
      rise2 = rise1;
      rise1 = rose;

      tick  = m_run && (m_pre == TICK - 1);
      nmode = m_mode ^ apply[2];
      zero  = apply[2] && !m_mode && (m_hex > 99);
      if (apply[1]) m_pre = 0;
      else if (m_run) m_pre = tick ? 0 : m_pre + 1;
      if (apply[1] || zero) m_hex = 0;
      else if (tick) m_hex = nmode ? (m_hex + 1) % 100 : (m_hex + 1) % 256;
      m_mode = nmode;
      if (apply[0]) m_run = !m_run;

      if (m_hex != ohex || m_mode != omode || m_run != orun) begin
        e.cyc  = cyc;
        e.hex  = m_hex;
        e.mode = m_mode;
        e.run  = m_run;
        q.push_back(e);
      end
    end
  end

  logic [7:0] p_hex  = '0;
  logic       p_mode = 1'b0;
  logic       p_run  = 1'b0;

  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst_n) begin
      p_hex  = hex;
      p_mode = mode;
      p_run  = run;
    end else if (hex !== p_hex || mode !== p_mode || run !== p_run) begin
      p_hex  = hex;
      p_mode = mode;
      p_run  = run;
      n_chk++;
      if (q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_change cyc=%0d got hex=%02h mode=%0b run=%0b, required no change",
                 cyc, hex, mode, run);
      end else begin
        e = q.pop_front();
        if (e.cyc != cyc || e.hex != int'(hex) || e.mode != mode || e.run != run) begin
          n_err++;
          $display("FAIL output_event got cyc=%0d hex=%02h mode=%0b run=%0b, required cyc=%0d hex=%02h mode=%0b run=%0b",
                   cyc, hex, mode, run, e.cyc, e.hex[7:0], e.mode, e.run);
        end
      end
    end
  end

  task automatic check(input string name, input int got, input int req);
    n_chk++;
    if (got != req) begin
      n_err++;
      $display("FAIL %s got=%0d required=%0d", name, got, req);
    end
  endtask

  task automatic press(input logic [2:0] m, input int hold, input int gap);
    @(negedge clk);
    raw = m;
    repeat (hold) @(negedge clk);
    raw = '0;
    repeat (gap) @(negedge clk);
  endtask

  // kind 0: hex == val, 1: hex >= val, 2: running with prescaler == val
  task automatic wait_model(input int kind, input int val, input string name);
    bit ok = 0;
    for (int k = 0; k < 4000 && !ok; k++) begin
      @(posedge clk);
      #1;
      case (kind)
        0:       ok = (m_hex == val);
        1:       ok = (m_hex >= val);
        2:       ok = m_run && (m_pre == val);
        default: ok = 1;
      endcase
    end
    if (!ok) begin
      n_chk++;
      n_err++;
      $display("FAIL timeout_%s got=none required=%0d", name, val);
    end
  endtask

  initial begin : stim
    logic [2:0] m;
    #1;
    check("reset_hex", hex, 0);
    check("reset_mode", mode, 0);
    check("reset_run", run, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    press(3'b001, 3, 20);
    check("bounce_no_run", run, 0);
    press(3'b001, 20, 10);
    check("held_run", run, 1);
    repeat (25) @(negedge clk);
    press(3'b001, 6, 20);
    press(3'b001, 6, 30);
    press(3'b010, 6, 5);

    wait_model(0, 255, "hex_ff");
    repeat (15) @(negedge clk);
    wait_model(1, 100, "hex_ge100");
    press(3'b100, 6, 10);
    wait_model(0, 99, "dec_99");
    repeat (15) @(negedge clk);
    press(3'b100, 6, 10);

    // Press events land 7 edges after the first sample: prescaler 2 -> 9.
    wait_model(2, 2, "pre_clr");
    press(3'b010, 6, 20);
    wait_model(2, 2, "pre_run");
    press(3'b001, 6, 20);

    for (int i = 0; i < 300; i++) begin
      m = 3'($urandom_range(1, 7));
      press(m, $urandom_range(1, 10), $urandom_range(2, 25));
    end
    repeat (15) @(negedge clk);
    if (!m_run) press(3'b001, 6, 10);
    if (m_mode) press(3'b100, 6, 10);
    press(3'b010, 6, 5);
    wait_model(0, 42, "hex_2a");
    repeat (2) @(negedge clk);

    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_hex", hex, 0);
    check("async_mode", mode, 0);
    check("async_run", run, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    check("idle_after_reset_hex", hex, 0);
    check("idle_after_reset_run", run, 0);
    press(3'b001, 6, 35);
    repeat (5) @(negedge clk);
    check("queue_drained", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
